// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetches the word at pc_in over a req/ack memory handshake,
// presents it to decode with valid/ready and pulses the PC write-enable on acceptance.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic              pc_wre,
    output logic              fetch_err
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                drop_q, drop_d;
    logic                drop_now;
    logic                pc_wre_d;

    // A flush arriving in the same cycle as the ack/timeout also discards the fetch.
    assign drop_now = drop_q | flush;

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        drop_d   = drop_q;
        pc_wre_d = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = pc_in;
                cnt_d  = '0;
                drop_d = 1'b0;
                if (pc_in[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    instr_d = NOP_WORD;
                    state_d = HOLD;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (imem_ack) begin
                    drop_d = 1'b0;
                    if (drop_now) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    instr_d = NOP_WORD;
                    drop_d  = 1'b0;
                    state_d = drop_now ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (dec_ready) begin
                    pc_wre_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    // Request/valid decode straight from the state flop so reset drops them at once.
    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = addr_q;
    assign instr_pc    = addr_q;
    assign instr_out   = instr_q;
    assign fetch_err   = err_q;
    assign pc_wre      = pc_wre_d;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetches, each checked
// cycle by cycle against a per-transaction timeline model of the fetch protocol.
module tb_instr_fetch_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          flush;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          dec_ready;
    logic          pc_wre;
    logic          fetch_err;

    instr_fetch_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .dec_ready  (dec_ready),
        .pc_wre     (pc_wre),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: sticky error, last latched address, word expected in HOLD
    logic        err_exp  = 1'b0;
    logic [31:0] addr_exp = '0;
    logic [31:0] out_exp  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs(input string tag, input bit req_e, input bit valid_e,
                                 input bit wre_e);
        chk({tag, ".req"},   32'(imem_req),    32'(req_e));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(valid_e));
        chk({tag, ".wre"},   32'(pc_wre),      32'(wre_e));
        chk({tag, ".addr"},  imem_addr,        addr_exp);
        chk({tag, ".ipc"},   instr_pc,         addr_exp);
        chk({tag, ".err"},   32'(fetch_err),   32'(err_exp));
        if (valid_e) chk({tag, ".instr"}, instr_out, out_exp);
    endtask

    // One fetch starting with the DUT idle. lat = REQ cycle index of the ack (>=TO: none),
    // wait_c = HOLD cycles with dec_ready low, flush_at = REQ cycle index of a flush (-1 none).
    task automatic run_fetch(input logic [31:0] pc, input int lat, input int wait_c,
                             input int flush_at, input bit flush_hold);
        bit mis, timeout, dropped;
        int req_cycles;
        mis     = (pc[1:0] != 2'b00);
        dropped = 1'b0;
        pc_in     = pc;
        flush     = 1'($urandom_range(0, 1));
        imem_ack  = 1'b0;
        dec_ready = 1'($urandom_range(0, 1));
        #1;
        check_outputs("idle", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        addr_exp = pc;
        if (mis) begin
            err_exp = 1'b1;
            out_exp = NOP;
        end else begin
            timeout    = (lat >= int'(TO));
            req_cycles = timeout ? int'(TO) : lat + 1;
            for (int k = 0; k < req_cycles; k++) begin
                pc_in      = $urandom;
                flush      = (k == flush_at);
                imem_ack   = (!timeout && k == lat);
                imem_rdata = imem_ack ? mem_word(pc) : $urandom;
                dec_ready  = 1'($urandom_range(0, 1));
                #1;
                check_outputs("req", 1'b1, 1'b0, 1'b0);
                if (flush) dropped = 1'b1;
                @(negedge clk);
            end
            imem_ack = 1'b0;
            if (timeout) begin
                err_exp = 1'b1;
                out_exp = NOP;
            end else begin
                out_exp = mem_word(pc);
            end
        end
        if (!dropped) begin
            for (int h = 0; h <= wait_c; h++) begin
                pc_in     = $urandom;
                dec_ready = (h >= wait_c);
                flush     = flush_hold && (h == wait_c);
                #1;
                check_outputs("hold", 1'b0, 1'b1, dec_ready && !flush);
                @(negedge clk);
            end
        end
        flush     = 1'b0;
        dec_ready = 1'b0;
    endtask

    // Assert reset asynchronously while the DUT sits in REQ or HOLD.
    task automatic reset_mid(input bit in_hold);
        pc_in     = 32'h80;
        flush     = 1'b0;
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        @(negedge clk);
        if (in_hold) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(32'h80);
            @(negedge clk);
            imem_ack = 1'b0;
        end
        #1;
        dec_ready = 1'b1;
        reset     = 1'b0;
        #1;
        err_exp  = 1'b0;
        addr_exp = '0;
        check_outputs(in_hold ? "rst_hold" : "rst_req", 1'b0, 1'b0, 1'b0);
        chk("rst.instr", instr_out, 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        dec_ready = 1'b0;
    endtask

    initial begin
        bit mis;
        int lat, limit, fat;
        logic [31:0] pc;
        reset      = 1'b0;
        pc_in      = '0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dec_ready  = 1'b0;
        #2;
        check_outputs("por", 1'b0, 1'b0, 1'b0);
        chk("por.instr", instr_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait back-to-back, delayed ack with stalled decode, flushed fetch
        run_fetch(32'h00, 0, 0, -1, 1'b0);
        run_fetch(32'h04, 0, 0, -1, 1'b0);
        run_fetch(32'h08, 3, 2, -1, 1'b0);
        run_fetch(32'h10, 5, 0, 1, 1'b0);
        run_fetch(32'h40, 0, 0, -1, 1'b0);
        run_fetch(32'h44, 1, 1, -1, 1'b1);
        // Misaligned and timed-out fetches
        run_fetch(32'h06, 0, 0, -1, 1'b0);
        run_fetch(32'h20, int'(TO), 1, -1, 1'b0);
        run_fetch(32'h24, int'(TO) - 1, 0, -1, 1'b0);
        // Asynchronous reset in REQ and in HOLD, then resume at the current pc
        reset_mid(1'b0);
        run_fetch(32'h84, 0, 0, -1, 1'b0);
        reset_mid(1'b1);
        run_fetch(32'h88, 2, 0, -1, 1'b0);

        for (int i = 0; i < 250; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            mis = (pc[1:0] != 2'b00);
            lat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, TO + 2))
                                              : int'($urandom_range(0, 3));
            limit = (lat >= int'(TO)) ? int'(TO) - 1 : lat;
            fat = -1;
            if (!mis && limit > 0 && $urandom_range(0, 3) == 0)
                fat = int'($urandom_range(0, limit - 1));
            run_fetch(pc, lat, int'($urandom_range(0, 3)), fat, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 60) == 0) begin
                reset_mid(1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
